// File: rtl/nand_rr_sched.sv
// nand_rr_sched: round-robin scheduler sharing a single 2-input NAND cell
// among N requesters. The granted operand pair is evaluated bit-serially,
// LSB first, and the W-bit result is returned with a one-cycle strobe.
//
// Handshake: req_valid[i] is held, with req_a/req_b stable, until the
// requester sees req_ready[i]. req_ready[i] is a registered one-cycle pulse
// in the first cycle after the grant edge. On the edge that ends that cycle,
// the requester may drop valid or present a new operation. Requests are
// only sampled in IDLE, so a held request that arrives while busy is served
// later. rsp_valid[g] is a one-cycle strobe with no back-pressure. rsp_y
// holds its value until the next result.

// Shared 2-input NAND cell.
module gnand (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_rr_sched #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_y,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  req_ready_q, req_ready_d;
  logic [N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_y_q, rsp_y_d;

  logic          found;
  logic [PW-1:0] gidx;
  logic          cell_y;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx[PW-1:0];
      end
    end
  end

  // The shared cell always sees the LSBs of the operand shift registers.
  gnand u_cell (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .y (cell_y)
  );

  // Next-state logic for the grant / bit-serial shift / response sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_y_d     = rsp_y_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_SHIFT;
          gnt_d       = gidx;
          a_sh_d      = req_a[gidx*W +: W];
          b_sh_d      = req_b[gidx*W +: W];
          cnt_d       = '0;
          ptr_d       = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
          req_ready_d = N'(1) << gidx;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Result enters at the MSB so after W steps bit k holds step k.
        res_d        = res_q >> 1;
        res_d[W-1]   = cell_y;
        if (cnt_q == CW'(W-1)) begin
          state_d     = S_DONE;
          rsp_valid_d = N'(1) << gnt_q;
          rsp_y_d     = res_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nand_rr_sched.sv
// Bench for nand_rr_sched: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a timeline model.
module tb_nand_rr_sched;
  localparam int N = 4;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           busy;
  logic [1:0]     dbg_state;

  logic           va [N];
  logic [W-1:0]   aa [N];
  logic [W-1:0]   bb [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = va[i];
      req_a[i*W +: W]  = aa[i];
      req_b[i*W +: W]  = bb[i];
    end
  end

  nand_rr_sched #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A grant opens a window of W+2 cycles: ready in its first cycle, busy for
  // W+1 cycles, the result in cycle W. Outside that window a grant goes to
  // the first valid requester found from the round-robin pointer.
  int cyc = 0;
  int gcyc = -1000;
  int gidx = 0;
  int ptr = 0;
  logic [W-1:0] y_model = '0;
  logic [W-1:0] pend_y = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    int j;
    bit done;
    if (!rst_n) begin
      gcyc = -1000;
      ptr = 0;
      y_model = '0;
      exp_q.delete();
    end else begin
      cyc++;
      if (cyc == gcyc + W) y_model = pend_y;
      if (cyc >= gcyc + W + 2) begin
        done = 0;
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (!done && va[j]) begin
            done = 1;
            gcyc = cyc;
            gidx = j;
            ptr = (j + 1) % N;
            pend_y = ~(aa[j] & bb[j]);
            exp_q.push_back(pend_y);
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("req_ready", 32'(req_ready), (cyc == gcyc) ? (32'd1 << gidx) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), (cyc == gcyc + W) ? (32'd1 << gidx) : 32'd0);
    chk("busy", 32'(busy), 32'((cyc >= gcyc) && (cyc <= gcyc + W)));
    chk("rsp_y", 32'(rsp_y), 32'(y_model));
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", 32'(rsp_y), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b0;
      aa[i] = '0;
      bb[i] = '0;
    end
  endtask

  // Waits (bounded) for a ready pulse; returns requester index and cycles waited.
  task automatic wait_grant(output int idx, output int waited);
    bit got;
    got = 0;
    idx = -1;
    waited = 0;
    for (int t = 1; t <= 100 && !got; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1;
        waited = t;
        for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
      end
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  // One operation from requester i with literal expected result and timing.
  task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ey);
    int g, w, n, bc;
    bit got;
    va[i] = 1'b1; aa[i] = a; bb[i] = b;
    wait_grant(g, w);
    chk("op_ready", 32'(req_ready), 32'd1 << i);
    va[i] = 1'b0;
    bc = busy ? 1 : 0;
    n = 0;
    got = 0;
    for (int t = 1; t <= 50 && !got; t++) begin
      @(negedge clk);
      n = t;
      if (busy) bc++;
      if (rsp_valid != '0) got = 1;
    end
    chk("op_latency", 32'(n), 32'(W));
    chk("op_rsp_valid", 32'(rsp_valid), 32'd1 << i);
    chk("op_rsp_y", 32'(rsp_y), 32'(ey));
    @(negedge clk);
    chk("op_busy_after", 32'(busy), 32'd0);
    chk("op_busy_cycles", 32'(bc), 32'(W + 1));
  endtask

  task automatic wait_cycles(input int n);
    for (int t = 0; t < n; t++) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g, w;
    int gl[6];
    idle_all();
    wait_cycles(2);
    rst_n = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Single op and data corners.
    do_op(0, 8'hF0, 8'hCC, 8'h3F);
    do_op(1, 8'hFF, 8'hFF, 8'h00);
    do_op(1, 8'h00, 8'h00, 8'hFF);
    do_op(1, 8'hA5, 8'hFF, 8'h5A);
    do_op(1, 8'h01, 8'h01, 8'hFE);

    // Result hold with no traffic.
    do_op(0, 8'hF0, 8'hCC, 8'h3F);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("hold_rsp_y", 32'(rsp_y), 32'h3F);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    // All four valid from reset: grants 0,1,2,3 spaced W+2.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b1; aa[i] = W'($urandom); bb[i] = W'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      wait_grant(g, w);
      chk("all4_order", 32'(g), 32'(k));
      if (k > 0) chk("all4_spacing", 32'(w), 32'(W + 2));
      if (g >= 0) va[g] = 1'b0;
    end
    wait_cycles(W + 3);

    // Requesters 1 and 3 continuously valid: strict alternation.
    va[1] = 1'b1; aa[1] = W'($urandom); bb[1] = W'($urandom);
    va[3] = 1'b1; aa[3] = W'($urandom); bb[3] = W'($urandom);
    for (int k = 0; k < 6; k++) begin
      wait_grant(g, w);
      gl[k] = g;
      chk("alt_order", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd3);
      if (k > 0) chk("alt_no_repeat", 32'(gl[k] != gl[k-1]), 32'd1);
      if (g >= 0) begin aa[g] = W'($urandom); bb[g] = W'($urandom); end
    end
    va[1] = 1'b0; va[3] = 1'b0;
    wait_cycles(W + 3);

    // Reset during bit step 4 of an op from requester 2.
    apply_reset();
    va[2] = 1'b1; aa[2] = 8'h5A; bb[2] = 8'h3C;
    wait_grant(g, w);
    chk("rstmid_ready", 32'(req_ready), 32'b0100);
    va[2] = 1'b0;
    wait_cycles(4);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_ready0", 32'(req_ready), 32'd0);
    chk("rstmid_valid0", 32'(rsp_valid), 32'd0);
    chk("rstmid_y0", 32'(rsp_y), 32'd0);
    chk("rstmid_busy0", 32'(busy), 32'd0);
    chk("rstmid_state0", 32'(dbg_state), 32'd0);
    va[0] = 1'b1; aa[0] = W'($urandom); bb[0] = W'($urandom);
    va[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(g, w);
    chk("rstmid_first_grant", 32'(g), 32'd0);
    va[0] = 1'b0;
    wait_grant(g, w);
    chk("rstmid_second_grant", 32'(g), 32'd2);
    va[2] = 1'b0;
    wait_cycles(W + 3);

    // Randomized traffic, protocol-compliant requesters.
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          if ($urandom_range(0, 1) == 1 && t < 500) begin
            aa[i] = W'($urandom); bb[i] = W'($urandom);
          end else begin
            va[i] = 1'b0;
          end
        end else if (!va[i] && t < 500 && $urandom_range(0, 3) == 0) begin
          va[i] = 1'b1; aa[i] = W'($urandom); bb[i] = W'($urandom);
        end
      end
    end
    idle_all();
    wait_cycles(W + 3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nand_rr_sched.md
# nand_rr_sched

Round-robin scheduler that shares one 2-input NAND cell (`gnand`) among N requesters. Each requester submits a W-bit operand pair. The block grants one requester at a time and evaluates the bitwise NAND bit-serially, LSB first, through the single shared cell. It then returns the W-bit result with a one-cycle response strobe addressed to the granted requester. It sits between requester logic and the shared NAND resource and is the only path to that cell.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 8, operand/result width in bits (1..32)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  N  bit i high = requester i presents an operation
- req_a  input  N*W  operand A of requester i at bits [i*W +: W]
- req_b  input  N*W  operand B of requester i at bits [i*W +: W]
- req_ready  output  N  one-hot, one-cycle acceptance pulse
- rsp_valid  output  N  one-hot, one-cycle result strobe
- rsp_y  output  W  result; holds last value until the next result
- busy  output  1  high while an operation is in flight

## Operation
- States:
  - IDLE: waits for requests.
  - SHIFT: W bit-steps.
  - DONE: one cycle, then always returns to IDLE.
- Grant:
  - In IDLE, at a rising edge with any req_valid set, grant g = first index with req_valid set, scanning p, p+1, … mod N, where p is the priority pointer.
  - On grant, latch req_a[g] and req_b[g] into shift registers, store g, clear the bit counter, and go to SHIFT.
- Pointer:
  - Updates to (g+1) mod N on grant.
  - Resets to 0, so requester 0 has first priority after reset.
- SHIFT step k (k = 0..W-1): cell inputs are the LSBs of the A/B shift registers. The cell output is shifted into the result register MSB-first, so that bit k of the result equals NAND(a[k], b[k]). A/B shift right by one each step.
- After step W-1, go to DONE. In DONE, the result register drives rsp_y and rsp_valid[g] is set.
- req_valid, req_a and req_b are ignored outside IDLE.
- Requester protocol: hold operands stable while valid until req_ready is seen. Drop valid, or present a new operation, on the edge that ends the ready cycle.
- No internal queueing. An ungranted request simply stays pending.

## Timing
- Cycle k is the clock period following edge E_k. Grant occurs at E_0.
- Cycle 0:
  - req_ready[g] = 1, registered.
  - State is SHIFT, bit step 0.
- Cycles 0..W-1: SHIFT, one bit per cycle.
- Cycle W:
  - DONE, rsp_valid[g] = 1.
  - rsp_y = final result, which then holds.
- Cycle W+1: IDLE.
- Earliest next grant is edge E_{W+2}. Minimum grant spacing is W+2 cycles (10 at W=8).
- busy = 1 in cycles 0..W and 0 in IDLE.
- Reset (asserted at any time, including mid-SHIFT):
  - State is IDLE immediately.
  - req_ready = 0, rsp_valid = 0, rsp_y = 0, busy = 0.
  - Pointer = 0, counter = 0.
  - The partial operation is discarded and no response is issued.
- A request arriving during SHIFT/DONE is not lost if held. It competes at the next IDLE edge.
- If no req_valid is set in IDLE, the block stays in IDLE and the pointer is unchanged.

## Test plan
- Single op, N=4, W=8: req_valid=0001, a=0xF0, b=0xCC → req_ready=0001 for one cycle, then rsp_valid=0001 exactly 8 cycles later with rsp_y=0x3F. busy is high for 9 cycles.
- Data corners on requester 1:
  - (0xFF, 0xFF) → 0x00
  - (0x00, 0x00) → 0xFF
  - (0xA5, 0xFF) → 0x5A
  - (0x01, 0x01) → 0xFE, which checks bit order.
- All four valid from reset and held until their ready → grants in order 0, 1, 2, 3 with ready pulses 10 cycles apart. Each rsp_valid is one-hot to the matching requester.
- Requesters 1 and 3 asserting continuously with fresh operands each time → grants alternate 1, 3, 1, 3 and requester 1 never wins twice in a row.
- Reset pulsed during SHIFT step 4 of an op from requester 2 → all outputs 0 immediately and no rsp_valid for that op. After release, with requesters 0 and 2 both valid, requester 0 is granted first.
- rsp_y hold: after a result of 0x3F with no further requests for 20 cycles → rsp_y stays 0x3F and rsp_valid stays 0000.
